fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output reordering stage placed directly downstream of the last SDF butterfly stage of the FFT chain. It consumes complex samples arriving in bit-reversed index order and re-emits each frame in natural order. It uses a ping-pong pair of frame buffers so that continuous input frames produce continuous output frames.

## Interface
Parameters:
- N, 128, FFT size in samples per frame; power of two, ≥ 4.
- WIDTH, 16, bit width of each real/imag component (two's complement).

Ports:
- clk  input  1  master clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- di_en  input  1  input sample valid.
- di_re  input  WIDTH  input sample, real part.
- di_im  input  WIDTH  input sample, imaginary part.
- do_en  output  1  output sample valid.
- do_re  output  WIDTH  output sample, real part.
- do_im  output  WIDTH  output sample, imaginary part.
- do_last  output  1  high together with do_en on the final (index N-1) sample of each output frame.

## Operation
- Storage: 2 banks × N entries × 2·WIDTH bits. Memory contents are not reset.
- Write side: wcnt (log2(N) bits) and wbank (1 bit). On each clock with di_en=1:
  - store {di_re, di_im} at bank wbank, address bitrev(wcnt) over log2(N) bits;
  - increment wcnt.
- When wcnt==N-1 and di_en=1 (frame complete):
  - wcnt wraps to 0 and wbank toggles;
  - a frame-ready event is raised for the completed bank.
- di_en may drop at any time inside a frame. wcnt holds and no data is lost. There is no frame-start marker; framing comes only from the count.
- Read side FSM, states IDLE and READ, with rcnt (log2(N) bits) and rbank:
  - IDLE → READ on a frame-ready event. rbank is set to the completed bank and rcnt to 0.
  - In READ, issue a read of address rcnt in bank rbank every clock, then increment rcnt.
  - At rcnt==N-1 with a frame-ready event pending or arriving in the same cycle: stay in READ, toggle rbank, set rcnt to 0. There is no idle gap.
  - At rcnt==N-1 with no frame-ready event pending or arriving: go to IDLE.
- The pending flag captures a frame-ready event that occurs while READ is busy. At most one event can be pending, because a frame takes ≥ N cycles to write.
- Bank-conflict freedom is guaranteed: the bank being read is next written only after its last read address has been issued.
- Output register:
  - do_re/do_im hold the read data;
  - do_en is high the cycle after a read was issued;
  - do_last marks the read issued at rcnt==N-1.
  - When do_en=0, do_re/do_im hold their last value.
- Result: output sample n of a frame equals input sample bitrev(n) of that frame.

## Timing
- Reset values: do_en=0, do_last=0, do_re=0, do_im=0. Internal state after reset: wcnt=0, wbank=0, rcnt=0, rbank=0, FSM=IDLE, pending=0.
- Latency: if the final input sample of a frame is sampled in cycle c, the first output sample has do_en=1 in cycle c+2. The frame's N outputs occupy cycles c+2 … c+N+1 with no gaps. do_last=1 in cycle c+N+1.
- Back-to-back frames (di_en continuously high) produce continuous do_en with no bubble between frames.
- Output is never stalled; there is no downstream backpressure.
- Reset mid-operation, effective the clock after rst is sampled:
  - any partial input frame is discarded;
  - any frame being read out is truncated immediately (do_en=0);
  - a pending frame is dropped.
- The first frame after reset starts at wcnt=0.
- di_en=1 in the same cycle as rst=1 is ignored.

## Test plan
- Reset: hold rst 3 cycles with di_en toggling → do_en=0, do_last=0, do_re=0, do_im=0 throughout and on the first cycle after release.
- N=8 single frame, di_re=k, di_im=-k for k=0..7 on consecutive cycles, final sample in cycle c → do_en high in cycles c+2..c+9 with do_re sequence 0,4,2,6,1,5,3,7 and do_im its negation; do_last only in c+9.
- N=8, three frames back-to-back, frame f carrying di_re=16f+k → do_en high for 24 consecutive cycles; each frame's values reordered as above; do_last high on output cycles 8, 16 and 24.
- N=8, di_en with random gaps (e.g. 1-on/2-off) across one frame → same reordered values; first output 2 cycles after the final input sample.
- N=8, rst pulsed after 5 samples of a frame, then a full frame di_re=100+k → only the 8 reordered values 100,104,102,106,101,105,103,107 are emitted, with no stale data.
- N=128, one frame di_re=k → do_re[n]=bitrev7(n) for n=0..127, e.g. n=1→64 and n=127→127; 128 consecutive do_en cycles.

Source files
------------

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the FFT output reorder stage: bit-reversed samples in,
// natural-order samples out.
interface fft_bitrev_reorder_if #(
    parameter int WIDTH = 16
);
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic             do_last;

    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im, do_last
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im, do_last
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer that turns bit-reversed FFT output into natural order.
// Writes land at bitrev(count), reads sweep linearly, so the read side stays trivial.
module fft_bitrev_reorder #(
    parameter int N     = 128,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_bitrev_reorder_if.slave  bus
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {IDLE, READ} state_t;

    logic [2*WIDTH-1:0] mem [0:2*N-1];

    state_t        state;
    logic [AW-1:0] wcnt;
    logic          wbank;
    logic [AW-1:0] rcnt;
    logic          rbank;
    logic          pending;
    logic          frame_rdy;
    logic [2*WIDTH-1:0] rd;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    assign frame_rdy = bus.di_en && (wcnt == LAST);
    assign rd        = mem[{rbank, rcnt}];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && bus.di_en)
            mem[{wbank, bitrev(wcnt)}] <= {bus.di_re, bus.di_im};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            wbank       <= 1'b0;
            rcnt        <= '0;
            rbank       <= 1'b0;
            pending     <= 1'b0;
            bus.do_en   <= 1'b0;
            bus.do_last <= 1'b0;
            bus.do_re   <= '0;
            bus.do_im   <= '0;
        end else begin
            if (bus.di_en) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST) wbank <= ~wbank;
            end

            bus.do_en   <= 1'b0;
            bus.do_last <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_rdy) begin
                        state <= READ;
                        rbank <= wbank;
                        rcnt  <= '0;
                    end
                end
                READ: begin
                    bus.do_re   <= rd[2*WIDTH-1:WIDTH];
                    bus.do_im   <= rd[WIDTH-1:0];
                    bus.do_en   <= 1'b1;
                    bus.do_last <= (rcnt == LAST);
                    if (rcnt == LAST) begin
                        rcnt <= '0;
                        // A frame finishing this cycle or earlier chains straight on, no bubble.
                        if (pending || frame_rdy) begin
                            rbank   <= ~rbank;
                            pending <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        rcnt <= rcnt + 1'b1;
                        if (frame_rdy) pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Drives one shared random stream into N=8 and N=128 instances and checks each
// against a frame-level reference model with per-cycle expected output timing.
module tb_fft_bitrev_reorder;
    localparam int W = 16;
    localparam int D = 1024;

    logic clk;
    logic rst;
    logic di_en;
    logic [W-1:0] di_re, di_im;

    fft_bitrev_reorder_if #(.WIDTH(W)) if8 ();
    fft_bitrev_reorder_if #(.WIDTH(W)) if128 ();

    assign if8.di_en   = di_en;
    assign if8.di_re   = di_re;
    assign if8.di_im   = di_im;
    assign if128.di_en = di_en;
    assign if128.di_re = di_re;
    assign if128.di_im = di_im;

    fft_bitrev_reorder #(.N(8),   .WIDTH(W)) dut8   (.clk(clk), .rst(rst), .bus(if8));
    fft_bitrev_reorder #(.N(128), .WIDTH(W)) dut128 (.clk(clk), .rst(rst), .bus(if128));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_on  = 1'b0;

    // reference model state, index 0 -> N=8, index 1 -> N=128
    logic [W-1:0] p_re [2][128];
    logic [W-1:0] p_im [2][128];
    int           pc   [2];
    int           e_t  [2][D];
    logic [W-1:0] e_re [2][D];
    logic [W-1:0] e_im [2][D];
    bit           e_last [2][D];
    int           eh [2];
    int           et [2];
    logic [W-1:0] lre [2];
    logic [W-1:0] lim [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int brev(input int v, input int bits);
        int r = 0;
        int x = v;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic model_edge(input int d, input bit en, input logic [W-1:0] re,
                              input logic [W-1:0] im, input bit r);
        int nn   = (d == 0) ? 8 : 128;
        int bits = (d == 0) ? 3 : 7;
        if (r) begin
            pc[d] = 0;
            while (et[d] > eh[d] && e_t[d][(et[d]-1) % D] >= cyc) et[d]--;
            lre[d] = '0;
            lim[d] = '0;
        end else if (en) begin
            p_re[d][pc[d]] = re;
            p_im[d][pc[d]] = im;
            pc[d]++;
            if (pc[d] == nn) begin
                for (int n = 0; n < nn; n++) begin
                    e_t[d][et[d] % D]    = cyc + 1 + n;
                    e_re[d][et[d] % D]   = p_re[d][brev(n, bits)];
                    e_im[d][et[d] % D]   = p_im[d][brev(n, bits)];
                    e_last[d][et[d] % D] = (n == nn - 1);
                    et[d]++;
                end
                pc[d] = 0;
            end
        end
    endtask

    task automatic step(input bit en, input logic [W-1:0] re, input logic [W-1:0] im, input bit r);
        di_en = en;
        di_re = re;
        di_im = im;
        rst   = r;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) model_edge(d, en, re, im, r);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, W'($urandom), W'($urandom), 1'b0);
    endtask

    always @(negedge clk) begin
        logic en, last;
        logic [W-1:0] re, im;
        int h;
        if (mon_on) begin
            for (int d = 0; d < 2; d++) begin
                en   = (d == 0) ? if8.do_en   : if128.do_en;
                last = (d == 0) ? if8.do_last : if128.do_last;
                re   = (d == 0) ? if8.do_re   : if128.do_re;
                im   = (d == 0) ? if8.do_im   : if128.do_im;
                h    = eh[d] % D;
                if (eh[d] != et[d] && e_t[d][h] == cyc) begin
                    chk(d == 0 ? "n8_do_en"   : "n128_do_en",   32'(en),   32'd1);
                    chk(d == 0 ? "n8_do_re"   : "n128_do_re",   32'(re),   32'(e_re[d][h]));
                    chk(d == 0 ? "n8_do_im"   : "n128_do_im",   32'(im),   32'(e_im[d][h]));
                    chk(d == 0 ? "n8_do_last" : "n128_do_last", 32'(last), 32'(e_last[d][h]));
                    lre[d] = e_re[d][h];
                    lim[d] = e_im[d][h];
                    eh[d]++;
                end else begin
                    chk(d == 0 ? "n8_idle_en"   : "n128_idle_en",   32'(en),   32'd0);
                    chk(d == 0 ? "n8_idle_last" : "n128_idle_last", 32'(last), 32'd0);
                    chk(d == 0 ? "n8_hold_re"   : "n128_hold_re",   32'(re),   32'(lre[d]));
                    chk(d == 0 ? "n8_hold_im"   : "n128_hold_im",   32'(im),   32'(lim[d]));
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            pc[d] = 0; eh[d] = 0; et[d] = 0; lre[d] = '0; lim[d] = '0;
        end
        di_en = 1'b0; di_re = '0; di_im = '0; rst = 1'b1;

        // reset held three cycles with di_en toggling
        for (int i = 0; i < 3; i++) begin
            step(i[0], W'($urandom), W'($urandom), 1'b1);
            mon_on = 1'b1;
        end
        idle(2);

        // single frame, re=k, im=-k
        for (int k = 0; k < 8; k++) step(1'b1, W'(k), W'(-k), 1'b0);
        idle(12);

        // three frames back to back
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 8; k++) step(1'b1, W'(16 * f + k), W'($urandom), 1'b0);
        idle(12);

        // 1-on/2-off gaps across one frame
        for (int k = 0; k < 8; k++) begin
            step(1'b1, W'(32 + k), W'($urandom), 1'b0);
            idle(2);
        end
        idle(12);

        // partial frame discarded by reset, then a clean frame
        for (int k = 0; k < 5; k++) step(1'b1, W'(200 + k), W'($urandom), 1'b0);
        step(1'b1, W'($urandom), W'($urandom), 1'b1);
        for (int k = 0; k < 8; k++) step(1'b1, W'(100 + k), W'($urandom), 1'b0);
        idle(12);

        // reset while a readout is in flight
        for (int k = 0; k < 19; k++) step(1'b1, W'($urandom), W'($urandom), 1'b0);
        step(1'b0, '0, '0, 1'b1);
        idle(12);

        // random sparse enables: exercises the pending path
        for (int i = 0; i < 300; i++)
            step(($urandom % 10) != 0, W'($urandom), W'($urandom), 1'b0);
        idle(12);

        // N=128 natural-order frame
        step(1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 128; k++) step(1'b1, W'(k), W'($urandom), 1'b0);
        idle(140);

        for (int d = 0; d < 2; d++) chk(d == 0 ? "n8_drain" : "n128_drain", 32'(eh[d]), 32'(et[d]));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
